// File: rtl/regfile_sb.sv
// Parametrised register file with NUM_RD combinational read ports, one write port,
// a per-register busy scoreboard and a one-register-per-cycle clear-sweep engine.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rsel,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wsel,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     mark,
  input  logic [ADDR_W-1:0]        msel,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   file [DEPTH];
  logic [DEPTH-1:0]    busy;

  logic idle;
  logic wr_en;
  logic mk_en;

  // Writes and marks only land while idle; register 0 is immutable when hardwired.
  assign idle  = (state == IDLE);
  assign wr_en = idle && we   && !((ZERO_REG != 0) && (wsel == '0));
  assign mk_en = idle && mark && !((ZERO_REG != 0) && (msel == '0));

  // NOTE: clr_busy/clr_done are registered alongside the state so they are glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            state    <= SWEEP;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        SWEEP: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state    <= DONE;
            clr_done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
          clr_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_done <= 1'b0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the array itself is reset because reads after reset must return zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) file[i] <= '0;
      busy <= '0;
    end else if (state == SWEEP) begin
      file[cnt] <= '0;
      busy[cnt] <= 1'b0;
    end else begin
      if (wr_en) begin
        file[wsel] <= wdata;
        busy[wsel] <= 1'b0;
      end
      // Issued after the write so a same-cycle mark leaves the register busy.
      if (mk_en) busy[msel] <= 1'b1;
    end
  end

  // NOTE: outputs get defaults first so the read mux never infers a latch.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] sel;
      sel = rsel[i*ADDR_W +: ADDR_W];
      rdata[i*DATA_W +: DATA_W] = file[sel];
      rbusy[i]                  = busy[sel];
      if ((BYPASS != 0) && wr_en && (wsel == sel)) begin
        rdata[i*DATA_W +: DATA_W] = wdata;
        rbusy[i] = (mk_en && (msel == sel)) ? busy[sel] : 1'b0;
      end
      if ((ZERO_REG != 0) && (sel == '0)) begin
        rdata[i*DATA_W +: DATA_W] = '0;
        rbusy[i]                  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, clear-sweep and reset
// sequences, and randomized traffic against a behavioural model (bypass on and off).
module tb_regfile_sb;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rsel;
  logic        we, mark, clr_req;
  logic [4:0]  wsel, msel;
  logic [31:0] wdata;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;
  logic        clr_busy_a, clr_busy_b, clr_done_a, clr_done_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .rsel(rsel), .rdata(rdata_a), .rbusy(rbusy_a),
    .we(we), .wsel(wsel), .wdata(wdata), .mark(mark), .msel(msel),
    .clr_req(clr_req), .clr_busy(clr_busy_a), .clr_done(clr_done_a));

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rsel(rsel), .rdata(rdata_b), .rbusy(rbusy_b),
    .we(we), .wsel(wsel), .wdata(wdata), .mark(mark), .msel(msel),
    .clr_req(clr_req), .clr_busy(clr_busy_b), .clr_done(clr_done_b));

  // Behavioural model: register contents, busy flags, and cycles of clear activity left
  // (DEPTH sweep cycles plus one done cycle; 0 means idle).
  logic [31:0] m_file [DEPTH];
  logic        m_busy [DEPTH];
  int          busy_left;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_file[i] = '0;
      m_busy[i] = 1'b0;
    end
    busy_left = 0;
  endtask

  function automatic void exp_read(input bit byp, input logic [4:0] s,
                                   output logic [31:0] d, output logic b);
    if (s == 5'd0) begin
      d = '0; b = 1'b0;
    end else if (byp && busy_left == 0 && we && wsel == s) begin
      d = wdata;
      b = (mark && msel == s) ? m_busy[s] : 1'b0;
    end else begin
      d = m_file[s]; b = m_busy[s];
    end
  endfunction

  task automatic check_all();
    logic [31:0] d;
    logic        b;
    for (int p = 0; p < 2; p++) begin
      exp_read(1'b1, rsel[p*5 +: 5], d, b);
      check($sformatf("byp_rdata%0d sel=%0d", p, rsel[p*5 +: 5]), 64'(rdata_a[p*32 +: 32]), 64'(d));
      check($sformatf("byp_rbusy%0d sel=%0d", p, rsel[p*5 +: 5]), 64'(rbusy_a[p]), 64'(b));
      exp_read(1'b0, rsel[p*5 +: 5], d, b);
      check($sformatf("nobyp_rdata%0d sel=%0d", p, rsel[p*5 +: 5]), 64'(rdata_b[p*32 +: 32]), 64'(d));
      check($sformatf("nobyp_rbusy%0d sel=%0d", p, rsel[p*5 +: 5]), 64'(rbusy_b[p]), 64'(b));
    end
    check("clr_busy_a", 64'(clr_busy_a), 64'(busy_left > 0));
    check("clr_busy_b", 64'(clr_busy_b), 64'(busy_left > 0));
    check("clr_done_a", 64'(clr_done_a), 64'(busy_left == 1));
    check("clr_done_b", 64'(clr_done_b), 64'(busy_left == 1));
  endtask

  task automatic model_edge();
    if (busy_left > 1) begin
      int idx;
      idx = DEPTH + 1 - busy_left;
      m_file[idx] = '0;
      m_busy[idx] = 1'b0;
      busy_left--;
    end else if (busy_left == 1) begin
      busy_left = 0;
    end else begin
      if (we && wsel != 5'd0) begin
        m_file[wsel] = wdata;
        m_busy[wsel] = 1'b0;
      end
      if (mark && msel != 5'd0) m_busy[msel] = 1'b1;
      if (clr_req) busy_left = DEPTH + 1;
    end
  endtask

  task automatic set_in(input logic w, input logic [4:0] ws, input logic [31:0] wd,
                        input logic m, input logic [4:0] ms,
                        input logic [4:0] rs0, input logic [4:0] rs1, input logic cr);
    we = w; wsel = ws; wdata = wd; mark = m; msel = ms;
    rsel = {rs1, rs0}; clr_req = cr;
  endtask

  // Called at a negedge with inputs applied: check outputs, then advance one clock.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wsel;
    logic [31:0] wdata;
    logic        mark;
    logic [4:0]  msel;
    logic [4:0]  rs0, rs1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int n_busy, n_done, done_at;

    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'h0,        32'h0,        2'b00};
    vecs[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd9, 32'hDEADBEEF, 32'h0,        2'b00};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    vecs[3]  = '{1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00};
    vecs[5]  = '{1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd5, 5'd9, 32'hDEADBEEF, 32'hA5A5A5A5, 2'b00};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd9, 32'h0,        32'hA5A5A5A5, 2'b00};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h0,        32'h0,        2'b11};
    vecs[8]  = '{1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 5'd7, 5'd5, 32'h77,       32'hDEADBEEF, 2'b00};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd0, 32'h77,       32'h0,        2'b00};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd5, 32'h77,       32'hDEADBEEF, 2'b00};
    vecs[11] = '{1'b1, 5'd7, 32'h1234,     1'b1, 5'd7, 5'd7, 5'd7, 32'h1234,     32'h1234,     2'b11};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd9, 32'h1234,     32'hA5A5A5A5, 2'b01};

    // Reset state.
    reset = 1'b0;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table (bypass instance against constants, both against the model).
    for (int v = 0; v < 13; v++) begin
      set_in(vecs[v].we, vecs[v].wsel, vecs[v].wdata, vecs[v].mark, vecs[v].msel,
             vecs[v].rs0, vecs[v].rs1, 1'b0);
      #1;
      check($sformatf("vec%0d rdata0", v), 64'(rdata_a[31:0]), 64'(vecs[v].e0));
      check($sformatf("vec%0d rdata1", v), 64'(rdata_a[63:32]), 64'(vecs[v].e1));
      check($sformatf("vec%0d rbusy", v), 64'(rbusy_a), 64'(vecs[v].eb));
      step();
    end

    // Clear sweep: fill the file, mark a few, then sweep while hammering reg 3.
    for (int r = 1; r < DEPTH; r++) begin
      set_in(1'b1, 5'(r), $urandom | 32'h1, 1'b0, 5'd0, 5'(r), 5'(r - 1), 1'b0);
      step();
    end
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd20, 1'b0);
    step();
    set_in(1'b1, 5'd2, 32'hBEEF, 1'b1, 5'd20, 5'd4, 5'd20, 1'b1);
    step();
    n_busy = 0; n_done = 0; done_at = -1;
    for (int c = 0; c < 36; c++) begin
      set_in(c < 33, 5'd3, 32'hFFFF, c < 33, 5'd3, 5'(c), 5'd3, c < 20);
      #1;
      if (clr_busy_a) n_busy++;
      if (clr_done_a) begin n_done++; done_at = c; end
      step();
    end
    check("sweep clr_busy cycles", 64'(n_busy), 64'(33));
    check("sweep clr_done pulses", 64'(n_done), 64'(1));
    check("sweep clr_done cycle", 64'(done_at), 64'(32));
    for (int r = 0; r < DEPTH; r += 2) begin
      set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(r), 5'(r + 1), 1'b0);
      #1;
      check($sformatf("swept reg%0d", r), 64'(rdata_a), 64'(0));
      check($sformatf("swept busy%0d", r), 64'(rbusy_a), 64'(0));
      step();
    end

    // Randomized traffic with occasional clear requests.
    for (int k = 0; k < 400; k++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 149) == 0));
      step();
    end
    // Let any in-flight sweep drain before the reset test.
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0);
    repeat (40) step();

    // Reset mid-sweep.
    for (int r = 10; r < DEPTH; r++) begin
      set_in(1'b1, 5'(r), $urandom | 32'h100, 1'b1, 5'(r), 5'(r), 5'd0, 1'b0);
      step();
    end
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd20, 5'd31, 1'b1);
    step();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd20, 5'd31, 1'b0);
    repeat (10) step();
    reset = 1'b0;
    #1;
    check("midsweep clr_busy", 64'(clr_busy_a), 64'(0));
    check("midsweep clr_done", 64'(clr_done_a), 64'(0));
    check("midsweep rdata", 64'(rdata_a), 64'(0));
    check("midsweep rbusy", 64'(rbusy_a), 64'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    for (int r = 0; r < 40; r++) begin
      set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(r), 5'(r + 16), 1'b0);
      #1;
      if (clr_done_a || clr_done_b) n_done++;
      step();
    end
    check("post-reset clr_done pulses", 64'(n_done), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 32x32 MIPS register file for the pipelined core.
- Provides NUM_RD combinational read ports and one write port, with optional hardwired zero register and optional write-to-read bypass.
- Holds a per-register busy scoreboard for load-use/hazard stall detection.
- Runs a sequential clear-sweep engine that zeroes the file one register per cycle on request, with a busy/done handshake.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: select width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2: number of read ports.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, is never busy.
- BYPASS, 1: 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rsel  input  NUM_RD*ADDR_W  packed read selects; port i uses bits [i*ADDR_W +: ADDR_W].
- rdata  output  NUM_RD*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W].
- rbusy  output  NUM_RD  per-port scoreboard busy flag for the selected register.
- we  input  1  write enable.
- wsel  input  ADDR_W  write select.
- wdata  input  DATA_W  write data.
- mark  input  1  set busy bit of msel (a producer was issued).
- msel  input  ADDR_W  register to mark busy.
- clr_req  input  1  start clear sweep; sampled in IDLE only.
- clr_busy  output  1  high while the sweep runs.
- clr_done  output  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (reset=0, asynchronous): all registers 0, all busy bits 0, FSM IDLE, clr_busy=0, clr_done=0. Release is applied synchronously to clk.
- Write: on a clk edge with we=1 and FSM in IDLE, file[wsel] <= wdata and busy[wsel] <= 0. With ZERO_REG=1 and wsel=0 the write is dropped.
- Mark: on a clk edge with mark=1 and FSM in IDLE, busy[msel] <= 1. Ignored when ZERO_REG=1 and msel=0.
- Mark and write to the same register in the same cycle: data is written and busy ends 1 (mark wins).
- Read is combinational and has zero latency:
  - rdata[i] = file[rsel[i]].
  - With ZERO_REG=1 and rsel[i]=0: rdata[i]=0 and rbusy[i]=0.
- Bypass (BYPASS=1, FSM IDLE, we=1, wsel==rsel[i], write not dropped):
  - rdata[i] = wdata.
  - rbusy[i] = 0, unless mark=1 with msel==rsel[i] in the same cycle; in that case rbusy[i] = busy[rsel[i]].
- Bypass disabled (BYPASS=0): rdata[i] is the old value and rbusy[i] = busy[rsel[i]] until the edge.
- Clear FSM states:
  - IDLE: if clr_req=1, go to SWEEP with counter cnt=0. A write/mark in the same cycle as clr_req still takes effect.
  - SWEEP: each cycle, file[cnt] <= 0, busy[cnt] <= 0, cnt <= cnt+1. When cnt == DEPTH-1, go to DONE. Sweep lasts exactly DEPTH cycles.
  - DONE: clr_done=1 for one cycle, then go to IDLE.
- clr_busy=1 in SWEEP and DONE.
- During SWEEP/DONE:
  - we and mark are ignored, clr_req is ignored, bypass is disabled.
  - Reads return the current array contents, so already-swept entries read 0.
- cnt wraps naturally at ADDR_W bits. Its value is irrelevant outside SWEEP and it is reset to 0 on entry.
- Reset asserted mid-sweep: immediate return to the reset state; no clr_done pulse.
- Multiple read ports with the same select return identical data and busy.

Test Plan:
- Reset then write: reset low 2 cycles; we=1, wsel=5, wdata=0xDEADBEEF; next cycle rsel[0]=5 -> rdata[0]=0xDEADBEEF, rbusy[0]=0; before the write, rdata=0.
- Zero register: we=1, wsel=0, wdata=0x12345678; mark msel=0 -> rsel=0 reads 0 and rbusy=0 on all ports (ZERO_REG=1).
- Bypass: same cycle we=1, wsel=9, wdata=0xA5A5A5A5, rsel[1]=9 -> rdata[1]=0xA5A5A5A5 combinationally. With BYPASS=0 -> old value 0 that cycle, new value next cycle.
- Scoreboard:
  - mark msel=7 -> rbusy=1 for rsel=7.
  - we wsel=7 -> busy cleared after the edge; rbusy=0 in the same cycle via bypass.
  - Simultaneous mark/write to 7 -> busy stays 1 and data is updated.
- Clear sweep: fill regs 1..31 with nonzero values; pulse clr_req -> clr_busy high for 33 cycles (32 SWEEP + DONE), clr_done high exactly 1 cycle at the end, all regs read 0, busy all 0. A write to reg 3 during the sweep is discarded.
- Reset mid-sweep: assert reset at sweep cycle 10 -> FSM IDLE, clr_busy=0, clr_done never pulses, all regs 0.
